// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm siren controller.
// Contents:
//   alarm_state_t : 3-bit state encoding, also used by the upstream mux
//                   stage's testbench and any status display.
//   max3          : constant helper used to size the delay counter.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_SIREN    = 3'd4,
        ST_REARM    = 3'd5
    } alarm_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_tick_timer.sv
// Tick prescaler plus loadable down counter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : restart prescaler at 0 and load counter with load_val
//   load_val  : delay length in ticks
//   clear     : zero prescaler and counter (timer idle)
//   tick      : one-cycle pulse each TICK_DIV cycles while counting
//   expire    : tick on which the counter is at 1 (last tick of the delay)
module alarm_tick_timer
    import alarm_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic             tick,
    output logic             expire
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             w_running;
    logic             w_pre_wrap;

    // Counter reaching zero parks the timer, so the counter never wraps.
    assign w_running  = (r_cnt != '0);
    assign w_pre_wrap = (r_pre == PRE_W'(TICK_DIV - 1));
    assign tick       = w_running && w_pre_wrap;
    assign expire     = tick && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_pre <= '0;
            r_cnt <= load_val;
        end else if (w_running) begin
            if (w_pre_wrap) begin
                r_pre <= '0;
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_siren_ctrl.sv
// Timed siren controller: turns armed/trip levels into exit delay, entry
// delay, bounded siren period and re-arm wait. Dropping active_i always
// disarms on the next edge.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   active_i  : system armed level
//   alarm_i   : sensor trip level
//   siren_o   : siren drive (SIREN only)
//   beep_o    : keypad beeper, toggles each tick in EXIT/ENTRY
//   armed_o   : high in ARMED, ENTRY, SIREN, REARM
//   state_o   : current state encoding
//
// state    | meaning
// DISARMED | idle, waiting for active_i
// EXIT     | exit delay running, trips ignored
// ARMED    | watching alarm_i
// ENTRY    | entry delay running, trip latched
// SIREN    | siren on for SIREN_LEN ticks
// REARM    | waiting for alarm_i to clear before re-arming
module alarm_siren_ctrl
    import alarm_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int EXIT_DLY  = 30,
    parameter int ENTRY_DLY = 15,
    parameter int SIREN_LEN = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active_i,
    input  logic       alarm_i,
    output logic       siren_o,
    output logic       beep_o,
    output logic       armed_o,
    output logic [2:0] state_o
);

    localparam int CNT_W = $clog2(max3(EXIT_DLY, ENTRY_DLY, SIREN_LEN) + 1);

    alarm_state_t     r_state;
    logic             r_siren;
    logic             r_beep;
    logic             r_armed;

    alarm_state_t     w_next;
    logic             w_load;
    logic             w_clear;
    logic [CNT_W-1:0] w_load_val;
    logic             w_tick;
    logic             w_expire;
    logic             w_next_beeping;

    alarm_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .clear    (w_clear),
        .tick     (w_tick),
        .expire   (w_expire)
    );

    // Timer load must coincide with the state change so each timed
    // state dwells exactly N*TICK_DIV cycles.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        w_load_val = '0;
        if (!active_i) begin
            w_next  = ST_DISARMED;
            w_clear = 1'b1;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    w_next     = ST_EXIT;
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(EXIT_DLY);
                end
                ST_EXIT: begin
                    if (w_expire) w_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (alarm_i) begin
                        w_next     = ST_ENTRY;
                        w_load     = 1'b1;
                        w_load_val = CNT_W'(ENTRY_DLY);
                    end
                end
                ST_ENTRY: begin
                    if (w_expire) begin
                        w_next     = ST_SIREN;
                        w_load     = 1'b1;
                        w_load_val = CNT_W'(SIREN_LEN);
                    end
                end
                ST_SIREN: begin
                    if (w_expire) w_next = ST_REARM;
                end
                ST_REARM: begin
                    // A stuck sensor keeps us here rather than re-sounding.
                    if (!alarm_i) w_next = ST_ARMED;
                end
                default: begin
                    w_next  = ST_DISARMED;
                    w_clear = 1'b1;
                end
            endcase
        end
    end

    assign w_next_beeping = (w_next == ST_EXIT) || (w_next == ST_ENTRY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DISARMED;
            r_siren <= 1'b0;
            r_beep  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_siren <= (w_next == ST_SIREN);
            r_armed <= (w_next == ST_ARMED) || (w_next == ST_ENTRY) ||
                       (w_next == ST_SIREN) || (w_next == ST_REARM);
            if (!w_next_beeping) begin
                r_beep <= 1'b0;
            end else if (w_next != r_state) begin
                r_beep <= 1'b1;
            end else if (w_tick) begin
                r_beep <= ~r_beep;
            end
        end
    end

    assign siren_o = r_siren;
    assign beep_o  = r_beep;
    assign armed_o = r_armed;
    assign state_o = r_state;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
module tb_alarm_siren_ctrl;

    localparam int TD  = 4;
    localparam int EXD = 3;
    localparam int ETD = 2;
    localparam int SLN = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       active_i = 1'b0;
    logic       alarm_i = 1'b0;
    logic       siren_o;
    logic       beep_o;
    logic       armed_o;
    logic [2:0] state_o;

    alarm_siren_ctrl #(
        .TICK_DIV  (TD),
        .EXIT_DLY  (EXD),
        .ENTRY_DLY (ETD),
        .SIREN_LEN (SLN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .active_i (active_i),
        .alarm_i  (alarm_i),
        .siren_o  (siren_o),
        .beep_o   (beep_o),
        .armed_o  (armed_o),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state number plus cycles spent in the current state.
    int m_st = 0;
    int m_el = 0;

    typedef struct {
        logic rst;
        logic act;
        logic alm;
        int   st;
        logic siren;
        logic beep;
        logic armed;
    } vec_t;

    vec_t vecs[12];

    function automatic int dwell_cycles(input int st);
        case (st)
            1:       return EXD * TD;
            3:       return ETD * TD;
            4:       return SLN * TD;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic a, input logic al);
        if (r || !a) begin
            m_st = 0;
            m_el = 0;
        end else begin
            case (m_st)
                0: begin m_st = 1; m_el = 0; end
                1, 3, 4: begin
                    if (m_el + 1 >= dwell_cycles(m_st)) begin
                        m_st = (m_st == 1) ? 2 : (m_st == 3) ? 4 : 5;
                        m_el = 0;
                    end else begin
                        m_el = m_el + 1;
                    end
                end
                2: if (al) begin m_st = 3; m_el = 0; end
                5: if (!al) begin m_st = 2; m_el = 0; end
                default: begin m_st = 0; m_el = 0; end
            endcase
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int exp_beep;
        exp_beep = ((m_st == 1 || m_st == 3) && ((m_el / TD) % 2 == 0)) ? 1 : 0;
        chk("state", int'(state_o), m_st);
        chk("siren", int'(siren_o), (m_st == 4) ? 1 : 0);
        chk("beep", int'(beep_o), exp_beep);
        chk("armed", int'(armed_o), (m_st >= 2 && m_st <= 5) ? 1 : 0);
    endtask

    task automatic cycle(input logic r, input logic a, input logic al);
        rst      = r;
        active_i = a;
        alarm_i  = al;
        @(posedge clk);
        model_step(r, a, al);
        #1;
    endtask

    task automatic count_state(input logic [2:0] st, input logic a, input logic al,
                               output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (state_o != st) break;
            n++;
            cycle(1'b0, a, al);
            check_model();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic ra, rl, rr;

        //          rst   act   alm   st siren beep armed
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].rst, vecs[i].act, vecs[i].alm);
            chk($sformatf("vec%0d_state", i), int'(state_o), vecs[i].st);
            chk($sformatf("vec%0d_siren", i), int'(siren_o), int'(vecs[i].siren));
            chk($sformatf("vec%0d_beep", i), int'(beep_o), int'(vecs[i].beep));
            chk($sformatf("vec%0d_armed", i), int'(armed_o), int'(vecs[i].armed));
        end

        // Full exit delay with an ignored trip pulse in the middle.
        cycle(1'b1, 1'b1, 1'b0); check_model();
        cycle(1'b0, 1'b1, 1'b0); check_model();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (state_o != 3'd1) break;
            n++;
            cycle(1'b0, 1'b1, (n == 5));
            check_model();
        end
        chk("exit_len", n, 12);
        chk("armed_after_exit", int'(state_o), 2);

        // Single-cycle trip: entry, siren, rearm, armed.
        cycle(1'b0, 1'b1, 1'b1); check_model();
        count_state(3'd3, 1'b1, 1'b0, n);
        chk("entry_len", n, 8);
        count_state(3'd4, 1'b1, 1'b0, n);
        chk("siren_len", n, 20);
        chk("rearm_after_siren", int'(state_o), 5);
        cycle(1'b0, 1'b1, 1'b0); check_model();
        chk("armed_after_rearm", int'(state_o), 2);

        // Stuck sensor holds REARM without re-sounding.
        cycle(1'b0, 1'b1, 1'b1); check_model();
        count_state(3'd3, 1'b1, 1'b1, n);
        count_state(3'd4, 1'b1, 1'b1, n);
        chk("stuck_siren_len", n, 20);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b1); check_model();
        end
        chk("stuck_rearm_state", int'(state_o), 5);
        chk("stuck_rearm_siren", int'(siren_o), 0);
        cycle(1'b0, 1'b1, 1'b0); check_model();
        chk("stuck_release_armed", int'(state_o), 2);

        // Disarm in the third entry cycle.
        cycle(1'b0, 1'b1, 1'b1); check_model();
        cycle(1'b0, 1'b1, 1'b0); check_model();
        cycle(1'b0, 1'b1, 1'b0); check_model();
        cycle(1'b0, 1'b0, 1'b0); check_model();
        chk("disarm_entry_state", int'(state_o), 0);
        chk("disarm_entry_armed", int'(armed_o), 0);
        chk("disarm_entry_siren", int'(siren_o), 0);

        // Disarm during siren.
        cycle(1'b0, 1'b1, 1'b0); check_model();
        count_state(3'd1, 1'b1, 1'b0, n);
        cycle(1'b0, 1'b1, 1'b1); check_model();
        count_state(3'd3, 1'b1, 1'b0, n);
        cycle(1'b0, 1'b1, 1'b0); check_model();
        chk("siren_on_mid", int'(siren_o), 1);
        cycle(1'b0, 1'b0, 1'b0); check_model();
        chk("disarm_siren_off", int'(siren_o), 0);
        chk("disarm_siren_state", int'(state_o), 0);

        // Reset mid-siren with active held: DISARMED then EXIT.
        cycle(1'b0, 1'b1, 1'b0); check_model();
        count_state(3'd1, 1'b1, 1'b0, n);
        cycle(1'b0, 1'b1, 1'b1); check_model();
        count_state(3'd3, 1'b1, 1'b0, n);
        cycle(1'b0, 1'b1, 1'b0); check_model();
        cycle(1'b1, 1'b1, 1'b0); check_model();
        chk("rst_siren_state", int'(state_o), 0);
        chk("rst_siren_off", int'(siren_o), 0);
        cycle(1'b0, 1'b1, 1'b0); check_model();
        chk("rst_release_exit", int'(state_o), 1);

        // Randomized traffic against the model.
        ra = 1'b1;
        rl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) ra = ~ra;
            if ($urandom_range(0, 5) == 0) rl = ~rl;
            cycle(rr, ra, rl);
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
